// File: rtl/rr_merge_stage_if.sv
// Handshake bundle for rr_merge_stage: grant channel in, payload buses,
// tagged output channel out. The slave modport is the merge stage's view.
// Optional macro MERGE_SEQNUM_EN widens out_d by SeqW sequence bits (MSBs).
interface rr_merge_stage_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SeqW = 4
);
  localparam int TagW = $clog2(N);
`ifdef MERGE_SEQNUM_EN
  localparam int SeqBits = SeqW;
`else
  localparam int SeqBits = 0 * SeqW;
`endif
  localparam int OutW = SeqBits + TagW + W;

  logic            grant_v;
  logic [TagW-1:0] grant_d;
  logic            grant_a;
  logic [N*W-1:0]  in_d;
  logic            out_v;
  logic [OutW-1:0] out_d;
  logic            out_a;

  modport slave (
    input  grant_v, grant_d, in_d, out_a,
    output grant_a, out_v, out_d
  );

  modport master (
    output grant_v, grant_d, in_d, out_a,
    input  grant_a, out_v, out_d
  );
endinterface

// File: rtl/rr_merge_stage.sv
// Merge stage behind the round-robin arbiter: accepts a grant index, samples
// that input's payload and queues {tag, payload} in a 2-entry FIFO.
// Optional macro MERGE_SEQNUM_EN prepends a SeqW-bit push sequence number.
module rr_merge_stage #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SeqW = 4
) (
  input  logic             clk,
  input  logic             reset,
  rr_merge_stage_if.slave  bus
);
  localparam int TagW = $clog2(N);
`ifdef MERGE_SEQNUM_EN
  localparam int SeqBits = SeqW;
`else
  localparam int SeqBits = 0 * SeqW;
`endif
  localparam int OutW = SeqBits + TagW + W;

  logic [OutW-1:0] mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            push;
  logic            pop;
  logic [W-1:0]    sel_pay;
  logic [OutW-1:0] wr_word;

  // Handshake outputs depend only on registered occupancy.
  assign bus.grant_a = (count != 2'd2);
  assign bus.out_v   = (count != 2'd0);
  assign push        = bus.grant_v & bus.grant_a;
  assign pop         = bus.out_v & bus.out_a;
  assign bus.out_d   = bus.out_v ? mem[rd_ptr] : '0;

  // Select the granted input's payload; out-of-range indices give zero.
  always_comb begin
    sel_pay = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.grant_d == TagW'(i)) sel_pay = bus.in_d[i*W +: W];
    end
  end

`ifdef MERGE_SEQNUM_EN
  logic [SeqW-1:0] seq;

  // Sequence counter advances once per accepted grant, wrapping naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    seq <= '0;
    else if (push) seq <= seq + 1'b1;
  end

  assign wr_word = {seq, bus.grant_d, sel_pay};
`else
  assign wr_word = {bus.grant_d, sel_pay};
`endif

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage written at the write pointer on each push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_word;
    end
  end
endmodule

// File: tb/tb_rr_merge_stage.sv
// Directed testbench for rr_merge_stage (N=4, W=8, SeqW=4).
// Works with or without MERGE_SEQNUM_EN defined.
module tb_rr_merge_stage;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SeqW = 4;
  localparam int TagW = 2;
`ifdef MERGE_SEQNUM_EN
  localparam int OW = SeqW + TagW + W;
`else
  localparam int OW = TagW + W;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rr_merge_stage_if #(.N(N), .W(W), .SeqW(SeqW)) bus ();

  rr_merge_stage #(.N(N), .W(W), .SeqW(SeqW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp    = 0;
  int n_bad    = 0;
  int seq_next = 0;

  function automatic logic [OW-1:0] exp_word(input int seq, input int tag, input int pay);
    logic [SeqW+TagW+W-1:0] full;
    full = {SeqW'(seq), TagW'(tag), W'(pay)};
    return OW'(full);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_stream_word(input int k);
    bus.grant_v = 1'b1;
    bus.grant_d = TagW'(k % N);
    bus.in_d    = '0;
    bus.in_d[(k % N)*W +: W] = W'(8'h40 + k);
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bus.grant_v = 1'b1;
    bus.grant_d = 2'd1;
    bus.in_d    = {4{8'hFF}};
    bus.out_a   = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (bus.out_v !== 1'b0) begin
        n_bad++; $display("FAIL reset_out_v: got %b expected 0", bus.out_v);
      end
      n_cmp++;
      if (bus.out_d !== OW'(0)) begin
        n_bad++; $display("FAIL reset_out_d: got %h expected 0", bus.out_d);
      end
    end
    bus.grant_v = 1'b0;
    #2 reset = 1'b1;
    step();
    n_cmp++;
    if (bus.grant_a !== 1'b1) begin
      n_bad++; $display("FAIL reset_grant_a: got %b expected 1", bus.grant_a);
    end
    n_cmp++;
    if (bus.out_v !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_out_v: got %b expected 0", bus.out_v);
    end
  endtask

  task automatic test_single();
    bus.in_d    = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.grant_d = 2'd2;
    bus.grant_v = 1'b1;
    bus.out_a   = 1'b1;
    step();
    n_cmp++;
    if (bus.out_v !== 1'b1) begin
      n_bad++; $display("FAIL single_out_v: got %b expected 1", bus.out_v);
    end
    n_cmp++;
    if (bus.out_d !== exp_word(seq_next, 2, 8'hA5)) begin
      n_bad++; $display("FAIL single_out_d: got %h expected %h", bus.out_d, exp_word(seq_next, 2, 8'hA5));
    end
    seq_next++;
    bus.grant_v = 1'b0;
    step();
    n_cmp++;
    if (bus.out_v !== 1'b0) begin
      n_bad++; $display("FAIL single_drain_v: got %b expected 0", bus.out_v);
    end
    n_cmp++;
    if (bus.out_d !== OW'(0)) begin
      n_bad++; $display("FAIL single_drain_d: got %h expected 0", bus.out_d);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    s0          = seq_next;
    bus.out_a   = 1'b0;
    bus.in_d    = {8'h33, 8'h00, 8'h22, 8'h11};
    bus.grant_d = 2'd0;
    bus.grant_v = 1'b1;
    step();
    n_cmp++;
    if (bus.grant_a !== 1'b1) begin
      n_bad++; $display("FAIL bp_grant_a_1: got %b expected 1", bus.grant_a);
    end
    n_cmp++;
    if (bus.out_d !== exp_word(s0, 0, 8'h11)) begin
      n_bad++; $display("FAIL bp_head_1: got %h expected %h", bus.out_d, exp_word(s0, 0, 8'h11));
    end
    bus.grant_d = 2'd1;
    step();
    n_cmp++;
    if (bus.grant_a !== 1'b0) begin
      n_bad++; $display("FAIL bp_full: got %b expected 0", bus.grant_a);
    end
    bus.grant_d = 2'd3;
    step();
    n_cmp++;
    if (bus.grant_a !== 1'b0) begin
      n_bad++; $display("FAIL bp_held: got %b expected 0", bus.grant_a);
    end
    n_cmp++;
    if (bus.out_v !== 1'b1 || bus.out_d !== exp_word(s0, 0, 8'h11)) begin
      n_bad++; $display("FAIL bp_stable: got v=%b d=%h expected v=1 d=%h", bus.out_v, bus.out_d, exp_word(s0, 0, 8'h11));
    end
    bus.out_a = 1'b1;
    step();
    n_cmp++;
    if (bus.grant_a !== 1'b1) begin
      n_bad++; $display("FAIL bp_freed: got %b expected 1", bus.grant_a);
    end
    n_cmp++;
    if (bus.out_d !== exp_word(s0 + 1, 1, 8'h22)) begin
      n_bad++; $display("FAIL bp_word_2: got %h expected %h", bus.out_d, exp_word(s0 + 1, 1, 8'h22));
    end
    step();
    n_cmp++;
    if (bus.out_v !== 1'b1 || bus.out_d !== exp_word(s0 + 2, 3, 8'h33)) begin
      n_bad++; $display("FAIL bp_word_3: got v=%b d=%h expected v=1 d=%h", bus.out_v, bus.out_d, exp_word(s0 + 2, 3, 8'h33));
    end
    bus.grant_v = 1'b0;
    step();
    n_cmp++;
    if (bus.out_v !== 1'b0) begin
      n_bad++; $display("FAIL bp_drained: got %b expected 0", bus.out_v);
    end
    seq_next += 3;
  endtask

  task automatic run_stream(input int n);
    bus.out_a = 1'b1;
    drive_stream_word(0);
    for (int k = 0; k < n; k++) begin
      step();
      n_cmp++;
      if (bus.out_v !== 1'b1 || bus.out_d !== exp_word(seq_next + k, k % N, 8'h40 + k)) begin
        n_bad++; $display("FAIL stream_word_%0d: got v=%b d=%h expected v=1 d=%h", k, bus.out_v, bus.out_d, exp_word(seq_next + k, k % N, 8'h40 + k));
      end
      n_cmp++;
      if (bus.grant_a !== 1'b1) begin
        n_bad++; $display("FAIL stream_grant_a_%0d: got %b expected 1", k, bus.grant_a);
      end
      if (k + 1 < n) drive_stream_word(k + 1);
      else           bus.grant_v = 1'b0;
    end
    step();
    n_cmp++;
    if (bus.out_v !== 1'b0) begin
      n_bad++; $display("FAIL stream_tail: got %b expected 0", bus.out_v);
    end
    seq_next += n;
  endtask

  task automatic test_streaming();
    run_stream(16);
  endtask

  task automatic test_mid_reset();
    bus.out_a   = 1'b0;
    bus.in_d    = {4{8'h5A}};
    bus.grant_d = 2'd1;
    bus.grant_v = 1'b1;
    step();
    step();
    bus.grant_v = 1'b0;
    n_cmp++;
    if (bus.grant_a !== 1'b0 || bus.out_v !== 1'b1) begin
      n_bad++; $display("FAIL mid_full: got a=%b v=%b expected a=0 v=1", bus.grant_a, bus.out_v);
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_v !== 1'b0) begin
      n_bad++; $display("FAIL mid_async_v: got %b expected 0", bus.out_v);
    end
    n_cmp++;
    if (bus.out_d !== OW'(0) || bus.grant_a !== 1'b1) begin
      n_bad++; $display("FAIL mid_async_state: got d=%h a=%b expected d=0 a=1", bus.out_d, bus.grant_a);
    end
    bus.out_a = 1'b1;
    #1 reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (bus.out_v !== 1'b0) begin
        n_bad++; $display("FAIL mid_stale_%0d: got %b expected 0", c, bus.out_v);
      end
    end
    seq_next = 0;
  endtask

  task automatic test_seqnum();
    run_stream(18);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.grant_v = 1'b0;
    bus.grant_d = '0;
    bus.in_d    = '0;
    bus.out_a   = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_mid_reset();
    test_seqnum();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
